// File: rtl/chimera_pkg.sv
// rtl/chimera_pkg.sv - shared types and constants for the chimera PMU sequencer
package chimera_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    PMU_IDLE    = 3'd0,
    PMU_ISO_ON  = 3'd1,
    PMU_RST_ON  = 3'd2,
    PMU_RST_OFF = 3'd3,
    PMU_ISO_OFF = 3'd4,
    PMU_RESP    = 3'd5
  } pmu_seq_state_e;

  localparam int unsigned PmuTimeoutCyclesDefault = 256;

  // Largest of three cycle counts; sizes the shared sequencing counter
  function automatic int unsigned pmu_max3(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/chimera_pmu_timer.sv
// rtl/chimera_pmu_timer.sv - saturating cycle counter with clear/enable/limit compare
module chimera_pmu_timer
  import chimera_pkg::*;
#(
  parameter int unsigned CntW = 9
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            clear_i,
  input  logic            enable_i,
  input  logic [CntW-1:0] limit_i,
  output logic            done_o
);

  logic [CntW-1:0] r_count;

  // Count up while enabled; clear wins over enable; hold at all-ones
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_count <= '0;
    end else if (enable_i && (r_count != {CntW{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign done_o = (r_count == limit_i);

endmodule

// File: rtl/chimera_pmu_sequencer.sv
// rtl/chimera_pmu_sequencer.sv - per-cluster isolation/reset power sequencer
module chimera_pmu_sequencer
  import chimera_pkg::*;
#(
  parameter int unsigned NumClusters   = 5,
  parameter int unsigned ResetCycles   = 16,
  parameter int unsigned SettleCycles  = 8,
  parameter int unsigned TimeoutCycles = PmuTimeoutCyclesDefault,
  localparam int unsigned IdxW = (NumClusters > 1) ? $clog2(NumClusters) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [IdxW-1:0]        cmd_cluster_i,
  input  logic                   cmd_on_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_err_o,
  output logic [NumClusters-1:0] rst_clusters_no,
  output logic [NumClusters-1:0] iso_en_clusters_o,
  input  logic [NumClusters-1:0] iso_ack_clusters_i,
  output logic [NumClusters-1:0] cluster_on_o,
  output logic                   busy_o
);

  localparam int unsigned CntW = $clog2(pmu_max3(ResetCycles, SettleCycles, TimeoutCycles)) + 1;
  localparam logic [CntW-1:0] ResetLim   = CntW'(ResetCycles - 1);
  localparam logic [CntW-1:0] SettleLim  = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] TimeoutLim = CntW'(TimeoutCycles - 1);

  pmu_seq_state_e         r_state;
  logic [IdxW-1:0]        r_idx;
  logic                   r_cmd_ready;
  logic                   r_rsp_valid;
  logic                   r_rsp_err;
  logic                   r_busy;
  logic [NumClusters-1:0] r_rst_n;
  logic [NumClusters-1:0] r_iso_en;
  logic [NumClusters-1:0] r_cluster_on;

  logic                   w_idx_ok;
  logic                   w_ack;
  logic                   w_tmr_clr;
  logic                   w_tmr_en;
  logic                   w_tmr_done;
  logic [CntW-1:0]        w_tmr_limit;

  assign w_idx_ok = (32'(cmd_cluster_i) < NumClusters);
  assign w_ack    = iso_ack_clusters_i[r_idx];
  assign w_tmr_en = (r_state != PMU_IDLE) && (r_state != PMU_RESP);

  // Timer limit per state; clear whenever the FSM is about to leave a counting
  // state so every counting state starts from zero on entry
  always_comb begin
    w_tmr_limit = TimeoutLim;
    w_tmr_clr   = 1'b1;
    case (r_state)
      PMU_ISO_ON: begin
        w_tmr_limit = TimeoutLim;
        w_tmr_clr   = w_ack | w_tmr_done;
      end
      PMU_ISO_OFF: begin
        w_tmr_limit = TimeoutLim;
        w_tmr_clr   = ~w_ack | w_tmr_done;
      end
      PMU_RST_ON: begin
        w_tmr_limit = ResetLim;
        w_tmr_clr   = w_tmr_done;
      end
      PMU_RST_OFF: begin
        w_tmr_limit = SettleLim;
        w_tmr_clr   = w_tmr_done;
      end
      default: begin
        w_tmr_limit = TimeoutLim;
        w_tmr_clr   = 1'b1;
      end
    endcase
  end

  chimera_pmu_timer #(
    .CntW (CntW)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (w_tmr_clr),
    .enable_i (w_tmr_en),
    .limit_i  (w_tmr_limit),
    .done_o   (w_tmr_done)
  );

  // Sequencing FSM: command latch, per-cluster reset/isolation/status bits, response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= PMU_IDLE;
      r_idx        <= '0;
      r_cmd_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_busy       <= 1'b0;
      r_rst_n      <= '0;
      r_iso_en     <= '1;
      r_cluster_on <= '0;
    end else begin
      case (r_state)
        PMU_IDLE: begin
          if (cmd_valid_i) begin
            r_idx       <= cmd_cluster_i;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (!w_idx_ok) begin
              r_state     <= PMU_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
            end else if (cmd_on_i == r_cluster_on[cmd_cluster_i]) begin
              r_state     <= PMU_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b0;
            end else if (!cmd_on_i) begin
              r_state                      <= PMU_ISO_ON;
              r_iso_en[cmd_cluster_i]      <= 1'b1;
              r_cluster_on[cmd_cluster_i]  <= 1'b0;
            end else begin
              r_state                 <= PMU_RST_OFF;
              r_rst_n[cmd_cluster_i]  <= 1'b1;
            end
          end
        end
        PMU_ISO_ON: begin
          if (w_ack) begin
            r_state        <= PMU_RST_ON;
            r_rst_n[r_idx] <= 1'b0;
          end else if (w_tmr_done) begin
            r_state             <= PMU_RESP;
            r_iso_en[r_idx]     <= 1'b1;
            r_rst_n[r_idx]      <= 1'b0;
            r_cluster_on[r_idx] <= 1'b0;
            r_rsp_valid         <= 1'b1;
            r_rsp_err           <= 1'b1;
          end
        end
        PMU_RST_ON: begin
          if (w_tmr_done) begin
            r_state     <= PMU_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
          end
        end
        PMU_RST_OFF: begin
          if (w_tmr_done) begin
            r_state         <= PMU_ISO_OFF;
            r_iso_en[r_idx] <= 1'b0;
          end
        end
        PMU_ISO_OFF: begin
          if (!w_ack) begin
            r_state             <= PMU_RESP;
            r_cluster_on[r_idx] <= 1'b1;
            r_rsp_valid         <= 1'b1;
            r_rsp_err           <= 1'b0;
          end else if (w_tmr_done) begin
            r_state             <= PMU_RESP;
            r_iso_en[r_idx]     <= 1'b1;
            r_rst_n[r_idx]      <= 1'b0;
            r_cluster_on[r_idx] <= 1'b0;
            r_rsp_valid         <= 1'b1;
            r_rsp_err           <= 1'b1;
          end
        end
        PMU_RESP: begin
          if (rsp_ready_i) begin
            r_state     <= PMU_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state <= PMU_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o       = r_cmd_ready;
  assign rsp_valid_o       = r_rsp_valid;
  assign rsp_err_o         = r_rsp_err;
  assign busy_o            = r_busy;
  assign rst_clusters_no   = r_rst_n;
  assign iso_en_clusters_o = r_iso_en;
  assign cluster_on_o      = r_cluster_on;

endmodule

// File: tb/tb_chimera_pmu_sequencer.sv
// tb/tb_chimera_pmu_sequencer.sv - directed self-checking bench for chimera_pmu_sequencer
module tb_chimera_pmu_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_cluster;
  logic       cmd_on;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_err;
  logic [4:0] rst_n;
  logic [4:0] iso_en;
  logic [4:0] iso_ack;
  logic [4:0] cl_on;
  logic       busy;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  chimera_pmu_sequencer dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .cmd_valid_i        (cmd_valid),
    .cmd_ready_o        (cmd_ready),
    .cmd_cluster_i      (cmd_cluster),
    .cmd_on_i           (cmd_on),
    .rsp_valid_o        (rsp_valid),
    .rsp_ready_i        (rsp_ready),
    .rsp_err_o          (rsp_err),
    .rst_clusters_no    (rst_n),
    .iso_en_clusters_o  (iso_en),
    .iso_ack_clusters_i (iso_ack),
    .cluster_on_o       (cl_on),
    .busy_o             (busy)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [4:0] e_rst, input logic [4:0] e_iso,
                            input logic [4:0] e_on);
    check({tag, ".rst_n"}, 32'(rst_n), 32'(e_rst));
    check({tag, ".iso_en"}, 32'(iso_en), 32'(e_iso));
    check({tag, ".cl_on"}, 32'(cl_on), 32'(e_on));
  endtask

  task automatic send(input logic [2:0] idx, input logic on);
    cmd_cluster = idx;
    cmd_on      = on;
    cmd_valid   = 1'b1;
    step(1);
    cmd_valid   = 1'b0;
  endtask

  task automatic rsp_accept(input string tag);
    rsp_ready = 1'b1;
    step(1);
    rsp_ready = 1'b0;
    check({tag, ".rsp_done"}, 32'(rsp_valid), 32'd0);
    check({tag, ".ready_back"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_cluster = 3'd0;
    cmd_on      = 1'b0;
    rsp_ready   = 1'b0;
    iso_ack     = 5'b11111;
    step(2);
    rst = 1'b0;
    step(1);
    check_outs("reset", 5'b00000, 5'b11111, 5'b00000);
    check("reset.cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset.busy", 32'(busy), 32'd0);

    // Power on cluster 2; ack drops 3 cycles after isolation release
    send(3'd2, 1'b1);
    check_outs("on2.rst_rise", 5'b00100, 5'b11111, 5'b00000);
    check("on2.cmd_ready", 32'(cmd_ready), 32'd0);
    check("on2.busy", 32'(busy), 32'd1);
    step(7);
    check("on2.settle_hold", 32'(iso_en), 32'h1f);
    step(1);
    check("on2.iso_fall", 32'(iso_en), 32'h1b);
    step(2);
    check("on2.no_rsp_yet", 32'(rsp_valid), 32'd0);
    iso_ack = 5'b11011;
    step(1);
    check("on2.rsp_valid", 32'(rsp_valid), 32'd1);
    check("on2.rsp_err", 32'(rsp_err), 32'd0);
    check_outs("on2.done", 5'b00100, 5'b11011, 5'b00100);
    rsp_accept("on2");

    // Repeat on-command: no-op, and response held while rsp_ready low
    send(3'd2, 1'b1);
    check("noop.rsp_valid", 32'(rsp_valid), 32'd1);
    check("noop.rsp_err", 32'(rsp_err), 32'd0);
    step(10);
    check("hold.rsp_valid", 32'(rsp_valid), 32'd1);
    check("hold.rsp_err", 32'(rsp_err), 32'd0);
    check("hold.cmd_ready", 32'(cmd_ready), 32'd0);
    check_outs("noop", 5'b00100, 5'b11011, 5'b00100);
    rsp_accept("noop");

    // Invalid index
    send(3'd7, 1'b1);
    check("bad.rsp_valid", 32'(rsp_valid), 32'd1);
    check("bad.rsp_err", 32'(rsp_err), 32'd1);
    check_outs("bad", 5'b00100, 5'b11011, 5'b00100);
    rsp_accept("bad");

    // Power off cluster 2; ack rises 4 cycles after isolation
    send(3'd2, 1'b0);
    check_outs("off2.iso", 5'b00100, 5'b11111, 5'b00000);
    step(3);
    check("off2.wait_ack", 32'(rst_n), 32'h04);
    iso_ack = 5'b11111;
    step(1);
    check("off2.rst_fall", 32'(rst_n), 32'h00);
    step(15);
    check("off2.rst_hold", 32'(rsp_valid), 32'd0);
    step(1);
    check("off2.rsp_valid", 32'(rsp_valid), 32'd1);
    check("off2.rsp_err", 32'(rsp_err), 32'd0);
    check_outs("off2.done", 5'b00000, 5'b11111, 5'b00000);
    rsp_accept("off2");

    // Power on cluster 1 with ack stuck high: timeout into safe off
    send(3'd1, 1'b1);
    check("to.rst_rise", 32'(rst_n), 32'h02);
    step(8);
    check("to.iso_fall", 32'(iso_en), 32'h1d);
    step(255);
    check("to.before_limit", 32'(rsp_valid), 32'd0);
    step(1);
    check("to.rsp_valid", 32'(rsp_valid), 32'd1);
    check("to.rsp_err", 32'(rsp_err), 32'd1);
    check_outs("to.safe", 5'b00000, 5'b11111, 5'b00000);
    rsp_accept("to");

    // Same again, ack arrives exactly on the timeout-limit cycle: ack wins
    send(3'd1, 1'b1);
    step(8);
    check("edge.iso_fall", 32'(iso_en), 32'h1d);
    step(255);
    check("edge.before_limit", 32'(rsp_valid), 32'd0);
    iso_ack = 5'b11101;
    step(1);
    check("edge.rsp_valid", 32'(rsp_valid), 32'd1);
    check("edge.rsp_err", 32'(rsp_err), 32'd0);
    check_outs("edge.on", 5'b00010, 5'b11101, 5'b00010);
    rsp_accept("edge");

    // Bring cluster 3 up, then abort its power-off with reset during RST_ON
    send(3'd3, 1'b1);
    step(8);
    check("on3.iso_fall", 32'(iso_en), 32'h15);
    iso_ack = 5'b10101;
    step(1);
    check_outs("on3.done", 5'b01010, 5'b10101, 5'b01010);
    rsp_accept("on3");
    send(3'd3, 1'b0);
    iso_ack = 5'b11101;
    step(1);
    check("off3.rst_on", 32'(rst_n), 32'h02);
    check("off3.busy", 32'(busy), 32'd1);
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check_outs("abort", 5'b00000, 5'b11111, 5'b00000);
    check("abort.cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.rsp_valid", 32'(rsp_valid), 32'd0);
    step(20);
    check("abort.no_rsp", 32'(rsp_valid), 32'd0);
    check("abort.idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
